// File: rtl/led_fader_if.sv
// rtl/led_fader_if.sv - frame-in / LED-out bundle for the LED afterglow stage
//   frame [15:0] : raw frame pattern, bit i = 1 requests LED i on (master -> slave)
//   led   [15:0] : PWM-modulated LED drive to pins (slave -> master)
//   modport master : frame generator / bench side
//   modport slave  : led_fader side
interface led_fader_if;
   logic [15:0] frame;
   logic [15:0] led;

   modport master (output frame, input led);
   modport slave  (input frame, output led);
endinterface

// File: rtl/led_fader.sv
// rtl/led_fader.sv - per-LED afterglow: full-on attack, 15-step decay, 4-bit PWM drive
//   DECAY_DIV : clock cycles per decay step (>= 2)
//   clk       : system clock, rising edge
//   rst       : synchronous, active-high reset
//   bus       : led_fader_if.slave (frame in, led out)
//   Optional build macro LED_FADER_ATTACK_EN: attack ramps up one step per tick
//   instead of jumping straight to full brightness.
module led_fader #(
   parameter int DECAY_DIV = 1_562_500
) (
   input  logic        clk,
   input  logic        rst,
   led_fader_if.slave  bus
);

   localparam int            DW       = $clog2(DECAY_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DECAY_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [3:0]    PWM_LAST = 4'd14;
   localparam logic [3:0]    LVL_MAX  = 4'd15;

   logic [15:0]   frame_q;
   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [3:0]    pwm_cnt;
   logic [3:0]    level     [16];
   logic [3:0]    level_nxt [16];
   logic [15:0]   led_q;

   assign tick    = (div_cnt == DIV_LAST);
   assign bus.led = led_q;

   // A lit channel always takes priority over a decay tick in the same cycle.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         level_nxt[i] = level[i];
`ifdef LED_FADER_ATTACK_EN
         if (frame_q[i]) begin
            if (tick && (level[i] != LVL_MAX))
               level_nxt[i] = level[i] + 4'd1;
         end else if (tick && (level[i] != 4'd0)) begin
            level_nxt[i] = level[i] - 4'd1;
         end
`else
         if (frame_q[i])
            level_nxt[i] = LVL_MAX;
         else if (tick && (level[i] != 4'd0))
            level_nxt[i] = level[i] - 4'd1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q <= 16'h0000;
         div_cnt <= '0;
         pwm_cnt <= 4'd0;
         led_q   <= 16'h0000;
         for (int i = 0; i < 16; i++)
            level[i] <= 4'd0;
      end else begin
         frame_q <= bus.frame;
         div_cnt <= tick ? '0 : (div_cnt + DIV_ONE);
         pwm_cnt <= (pwm_cnt == PWM_LAST) ? 4'd0 : (pwm_cnt + 4'd1);
         for (int i = 0; i < 16; i++) begin
            level[i] <= level_nxt[i];
            // Phase runs 0..14, so level 15 is always on and level 0 always off.
            led_q[i] <= (level[i] > pwm_cnt);
         end
      end
   end

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - directed self-checking bench for led_fader (DECAY_DIV = 4)
module tb_led_fader;

   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   led_fader_if bus ();

   led_fader #(.DECAY_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model of the intended behaviour, advanced on the same edges.
   logic [15:0] m_fq;
   int          m_div;
   int          m_pwm;
   int          m_level [16];
   logic [15:0] m_led;

   always @(posedge clk) begin
      if (rst) begin
         m_fq  <= 16'h0000;
         m_div <= 0;
         m_pwm <= 0;
         m_led <= 16'h0000;
         for (int i = 0; i < 16; i++) m_level[i] <= 0;
      end else begin
         m_fq  <= bus.frame;
         m_div <= (m_div + 1) % DIV;
         m_pwm <= (m_pwm + 1) % 15;
         for (int i = 0; i < 16; i++) begin
            m_led[i] <= (m_level[i] > m_pwm);
`ifdef LED_FADER_ATTACK_EN
            if (m_fq[i]) m_level[i] <= (m_div == DIV - 1) ? ((m_level[i] < 15) ? m_level[i] + 1 : 15) : m_level[i];
            else         m_level[i] <= (m_div == DIV - 1 && m_level[i] > 0) ? m_level[i] - 1 : m_level[i];
`else
            if (m_fq[i]) m_level[i] <= 15;
            else         m_level[i] <= (m_div == DIV - 1 && m_level[i] > 0) ? m_level[i] - 1 : m_level[i];
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int nz;
      rst = 1'b1;
      bus.frame = 16'hFFFF;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (bus.led !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold cycle %0d got %h expected 0000", k, bus.led);
         end
      end
      nz = 0;
      for (int i = 0; i < 16; i++) if (dut.level[i] !== 4'd0) nz++;
      checks++;
      if (nz != 0 || dut.pwm_cnt !== 4'd0 || dut.div_cnt !== 2'd0 || dut.frame_q !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state nonzero_levels %0d pwm %0d div %0d fq %h expected 0 0 0 0000",
                  nz, dut.pwm_cnt, dut.div_cnt, dut.frame_q);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.led !== 16'h0000) begin
         errors++;
         $display("FAIL reset_first_after got %h expected 0000", bus.led);
      end
      step();
      checks++;
      if (bus.led !== 16'h0000) begin
         errors++;
         $display("FAIL reset_second_after got %h expected 0000", bus.led);
      end
`ifndef LED_FADER_ATTACK_EN
      step();
      checks++;
      if (bus.led !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_third_after got %h expected ffff", bus.led);
      end
      nz = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (bus.led !== 16'hFFFF) nz++;
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL reset_steady_on off_cycles %0d expected 0", nz);
      end
`endif
   endtask

   task automatic test_attack_fall();
      int   highs, ntrans, bad_step, bad_space, last_change, last_on, mism;
      logic [3:0] prev, cur;
      bus.frame = 16'h0000;
      repeat (80) step();
      checks++;
      if (bus.led !== 16'h0000) begin
         errors++;
         $display("FAIL idle_dark got %h expected 0000", bus.led);
      end
      bus.frame = 16'h0001;
      step();
      step();
      checks++;
      if (bus.led[0] !== 1'b0) begin
         errors++;
         $display("FAIL attack_edge2 got %b expected 0", bus.led[0]);
      end
      step();
      checks++;
      if (bus.led[0] !== 1'b1) begin
         errors++;
         $display("FAIL attack_edge3 got %b expected 1", bus.led[0]);
      end
      highs = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (bus.led[0] === 1'b1) highs++;
      end
      checks++;
      if (highs != 15) begin
         errors++;
         $display("FAIL attack_duty got %0d expected 15", highs);
      end
      bus.frame = 16'h0000;
      prev = dut.level[0];
      cur = prev;
      ntrans = 0; bad_step = 0; bad_space = 0; last_change = -1; last_on = 0; mism = 0;
      for (int c = 1; c <= 70; c++) begin
         step();
         cur = dut.level[0];
         if (cur !== prev) begin
            ntrans++;
            if (cur !== 4'(prev - 4'd1)) bad_step++;
            if (last_change >= 0 && (c - last_change) != DIV) bad_space++;
            last_change = c;
            prev = cur;
         end
         if (bus.led[0] === 1'b1) last_on = c;
         if (bus.led !== m_led) mism++;
      end
      checks++;
      if (ntrans != 15 || bad_step != 0 || bad_space != 0) begin
         errors++;
         $display("FAIL fall_steps transitions %0d bad_step %0d bad_spacing %0d expected 15 0 0",
                  ntrans, bad_step, bad_space);
      end
      checks++;
      if (cur !== 4'd0 || last_on > 62) begin
         errors++;
         $display("FAIL fall_end level %0d last_on_cycle %0d expected 0 and <=62", cur, last_on);
      end
      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL fall_pwm model_mismatch_cycles %0d expected 0", mism);
      end
      highs = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (bus.led[0] !== 1'b0) highs++;
      end
      checks++;
      if (highs != 0) begin
         errors++;
         $display("FAIL fall_stays_dark on_cycles %0d expected 0", highs);
      end
   endtask

   task automatic test_set_tick();
      bit found;
      bus.frame = 16'h0020;
      repeat (5) step();
      bus.frame = 16'h0000;
      found = 0;
      for (int k = 0; k < 120 && !found; k++) begin
         step();
         if (m_level[5] == 7 && m_div == 2) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL set_tick_setup got not_found expected level7_div2 within 120 cycles");
      end else begin
         bus.frame = 16'h0020;
         step();
         checks++;
         if (dut.tick !== 1'b1 || dut.level[5] !== 4'd7 || dut.frame_q[5] !== 1'b1) begin
            errors++;
            $display("FAIL set_tick_pre tick %b level %0d fq %b expected 1 7 1",
                     dut.tick, dut.level[5], dut.frame_q[5]);
         end
         step();
         checks++;
         if (dut.level[5] !== 4'd15) begin
            errors++;
            $display("FAIL set_wins_over_tick got %0d expected 15", dut.level[5]);
         end
      end
   endtask

   task automatic test_relight();
      bit found;
      int offs;
      bus.frame = 16'h0008;
      repeat (5) step();
      bus.frame = 16'h0000;
      found = 0;
      for (int k = 0; k < 120 && !found; k++) begin
         step();
         if (m_level[3] == 4) found = 1;
      end
      checks++;
      if (!found || dut.level[3] !== 4'd4) begin
         errors++;
         $display("FAIL relight_pre found %0d level %0d expected 1 4", found, dut.level[3]);
      end
      bus.frame = 16'h0008;
      step();
      step();
      checks++;
      if (dut.level[3] !== 4'd15) begin
         errors++;
         $display("FAIL relight_level got %0d expected 15", dut.level[3]);
      end
      offs = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (bus.led[3] !== 1'b1) offs++;
      end
      checks++;
      if (offs != 0) begin
         errors++;
         $display("FAIL relight_led_on off_cycles %0d expected 0", offs);
      end
   endtask

   task automatic test_reset_mid_fade();
      int nz;
      bus.frame = 16'hFFFF;
      repeat (4) step();
      bus.frame = 16'h0000;
      repeat (10) step();
      rst = 1'b1;
      step();
      nz = 0;
      for (int i = 0; i < 16; i++) if (dut.level[i] !== 4'd0) nz++;
      checks++;
      if (bus.led !== 16'h0000 || nz != 0) begin
         errors++;
         $display("FAIL midfade_reset led %h nonzero_levels %0d expected 0000 0", bus.led, nz);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.led !== 16'h0000 || dut.pwm_cnt !== 4'd1 || dut.div_cnt !== 2'd1) begin
         errors++;
         $display("FAIL midfade_after led %h pwm %0d div %0d expected 0000 1 1",
                  bus.led, dut.pwm_cnt, dut.div_cnt);
      end
      nz = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (bus.led !== 16'h0000) nz++;
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL midfade_no_glow lit_cycles %0d expected 0", nz);
      end
   endtask

   task automatic test_independence();
      logic [15:0] pat;
      for (int p = 0; p < 6; p++) begin
         pat = (p % 2 == 0) ? 16'hAAAA : 16'h5555;
         bus.frame = pat;
         for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (bus.led !== m_led) begin
               errors++;
               $display("FAIL indep_model phase %0d cycle %0d got %h expected %h", p, k, bus.led, m_led);
            end
         end
`ifndef LED_FADER_ATTACK_EN
         checks++;
         if ((bus.led & pat) !== pat) begin
            errors++;
            $display("FAIL indep_lit phase %0d got %h expected lit bits %h", p, bus.led, pat);
         end
`endif
      end
   endtask

   task automatic test_attack_ramp();
      int   ntrans, bad_step, bad_space, last_change, mism;
      logic [3:0] prev, cur;
      rst = 1'b1;
      bus.frame = 16'h8000;
      step();
      rst = 1'b0;
      prev = dut.level[15];
      cur = prev;
      ntrans = 0; bad_step = 0; bad_space = 0; last_change = -1; mism = 0;
      for (int c = 1; c <= 80; c++) begin
         step();
         cur = dut.level[15];
         if (cur !== prev) begin
            ntrans++;
            if (cur !== 4'(prev + 4'd1)) bad_step++;
            if (last_change >= 0 && (c - last_change) != DIV) bad_space++;
            last_change = c;
            prev = cur;
         end
         if (bus.led !== m_led) mism++;
      end
      checks++;
      if (ntrans != 15 || bad_step != 0 || bad_space != 0) begin
         errors++;
         $display("FAIL ramp_steps transitions %0d bad_step %0d bad_spacing %0d expected 15 0 0",
                  ntrans, bad_step, bad_space);
      end
      checks++;
      if (cur !== 4'd15 || mism != 0) begin
         errors++;
         $display("FAIL ramp_end level %0d model_mismatch %0d expected 15 0", cur, mism);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.frame = 16'hFFFF;
      test_reset();
`ifdef LED_FADER_ATTACK_EN
      test_attack_ramp();
      test_independence();
`else
      test_attack_fall();
      test_set_tick();
      test_relight();
      test_reset_mid_fade();
      test_independence();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
